// File: rtl/mem_port_arbiter_if.sv
// Request/ack and memory bus bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for one fixed-latency single-ported memory, data port first.
// Optional wait-cycle counters are built when MEMARB_STALL_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    mem_port_arbiter_if.slave        bus_io,
    output logic [15:0]              if_stall_cnt_o,
    output logic [15:0]              d_stall_cnt_o
);
    localparam int unsigned CntW = $clog2(MEM_LAT + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] LatLast   = CntW'(MEM_LAT);
    localparam logic [StW-1:0]  StarveTop = StW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic            data_sel_q, data_sel_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic            if_ack_q, if_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            grant_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        data_sel_d = data_sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        grant_data = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.d_req || bus_io.if_req) begin
                    // Fetch only wins a contested cycle once the guard has saturated.
                    grant_data = bus_io.d_req && !(bus_io.if_req && starve_q == StarveTop);
                    data_sel_d = grant_data;
                    we_d       = grant_data && bus_io.d_we;
                    addr_d     = grant_data ? bus_io.d_addr : bus_io.if_addr;
                    wdata_d    = grant_data ? bus_io.d_wdata : '0;
                    starve_d   = (grant_data && bus_io.if_req) ? starve_q + StW'(1) : '0;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = grant_data && bus_io.d_we;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LatLast) begin
                    if (data_sel_q) begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = bus_io.mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_io.mem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            starve_q   <= '0;
            data_sel_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            data_sel_q <= data_sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus_io.mem_en    = mem_en_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_addr  = addr_q;
    assign bus_io.mem_wdata = wdata_q;
    assign bus_io.if_ack    = if_ack_q;
    assign bus_io.if_rdata  = if_rdata_q;
    assign bus_io.d_ack     = d_ack_q;
    assign bus_io.d_rdata   = d_rdata_q;

`ifdef MEMARB_STALL_CNT_EN
    logic [15:0] if_stall_q, if_stall_d;
    logic [15:0] d_stall_q, d_stall_d;

    always_comb begin
        if_stall_d = if_stall_q;
        d_stall_d  = d_stall_q;
        if (bus_io.if_req && !if_ack_q && if_stall_q != 16'hFFFF) begin
            if_stall_d = if_stall_q + 16'd1;
        end
        if (bus_io.d_req && !d_ack_q && d_stall_q != 16'hFFFF) begin
            d_stall_d = d_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            if_stall_q <= if_stall_d;
            d_stall_q  <= d_stall_d;
        end
    end

    assign if_stall_cnt_o = if_stall_q;
    assign d_stall_cnt_o  = d_stall_q;
`else
    assign if_stall_cnt_o = 16'h0000;
    assign d_stall_cnt_o  = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model checked every cycle,
// directed scenarios with literal expectations, and a MEM_LAT=4 instance for latency.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned LAT  = 1;
    localparam int unsigned SMAX = 3;
`ifdef MEMARB_STALL_CNT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] if_stall_cnt, d_stall_cnt, if_stall4, d_stall4;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus4 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .reset_i(reset), .bus_io(bus.slave),
        .if_stall_cnt_o(if_stall_cnt), .d_stall_cnt_o(d_stall_cnt)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_MAX(SMAX)) dut4 (
        .clk_i(clk), .reset_i(reset), .bus_io(bus4.slave),
        .if_stall_cnt_o(if_stall4), .d_stall_cnt_o(d_stall4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Unified memory contents; unwritten words read as a fixed address pattern.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Model: each grant at cycle t fixes mem_en at t+1, ack at t+2+LAT, next grant >= t+3+LAT.
    bit          valid = 1'b0;
    int          free_at, en_at = -1, ack_at = -1;
    bit          w_data, w_we;
    logic [31:0] w_val, w_wdata;
    logic [31:0] e_maddr, e_ifr, e_dr;
    int          starve, e_ifs, e_ds;
    bit          g_log[$];
    int          rd_due = -1;
    logic [31:0] rd_val;

    task automatic model_step();
        int c;
        bit pick_d;
        c = cyc;
        if (reset) begin
            valid = 1'b1; free_at = c + 1; en_at = -1; ack_at = -1;
            e_maddr = '0; e_ifr = '0; e_dr = '0; w_we = 1'b0;
            starve = 0; e_ifs = 0; e_ds = 0;
        end else if (valid) begin
            if (StallEn) begin
                if (bus.if_req && !(c == ack_at && !w_data) && e_ifs < 65535) e_ifs++;
                if (bus.d_req && !(c == ack_at && w_data) && e_ds < 65535) e_ds++;
            end
            if (c + 1 == ack_at) begin
                if (!w_data) e_ifr = w_val;
                else if (!w_we) e_dr = w_val;
            end
            if (c >= free_at && (bus.if_req || bus.d_req)) begin
                pick_d = bus.d_req && !(bus.if_req && starve == SMAX);
                starve = (pick_d && bus.if_req) ? starve + 1 : 0;
                w_data  = pick_d;
                w_we    = pick_d && bus.d_we;
                e_maddr = pick_d ? bus.d_addr : bus.if_addr;
                w_wdata = bus.d_wdata;
                w_val   = mem_rd(e_maddr);
                en_at   = c + 1;
                ack_at  = c + 2 + LAT;
                free_at = c + 3 + LAT;
                g_log.push_back(pick_d);
            end
        end
    endtask

    task automatic compare();
        bit exp_en;
        exp_en = (cyc == en_at);
        chk("mem_en", {31'b0, bus.mem_en}, {31'b0, exp_en});
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_en && w_we});
        chk("mem_addr", bus.mem_addr, e_maddr);
        if (exp_en && w_we) chk("mem_wdata", bus.mem_wdata, w_wdata);
        chk("if_ack", {31'b0, bus.if_ack}, {31'b0, (cyc == ack_at) && !w_data});
        chk("d_ack", {31'b0, bus.d_ack}, {31'b0, (cyc == ack_at) && w_data});
        chk("if_rdata", bus.if_rdata, e_ifr);
        chk("d_rdata", bus.d_rdata, e_dr);
        chk("if_stall_cnt", {16'b0, if_stall_cnt}, 32'(e_ifs));
        chk("d_stall_cnt", {16'b0, d_stall_cnt}, 32'(e_ds));
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
            cyc++;
            @(negedge clk);
            if (valid) compare();
            if (bus.mem_en === 1'b1) begin
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                else begin
                    rd_due = cyc + LAT;
                    rd_val = mem_rd(bus.mem_addr);
                end
            end
            bus.mem_rdata = (cyc == rd_due) ? rd_val : (32'hBAD0_0000 | 32'(cyc[15:0]));
        end
    end

    task automatic goto_pos(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic do_req(input bit is_d, input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
        bit got;
        goto_pos(cyc + 1);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = a;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = is_d ? (bus.d_ack === 1'b1) : (bus.if_ack === 1'b1);
        end
        chk(is_d ? "d_ack_seen" : "if_ack_seen", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (is_d) begin
            bus.d_req = 1'b0; bus.d_we = 1'b0;
        end else bus.if_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0, n_ack, n_en, ack_c, due, base;
        bit seq[$];
        bit exp_seq[8];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        bus4.if_req = 0; bus4.if_addr = 0; bus4.d_req = 0; bus4.d_we = 0;
        bus4.d_addr = 0; bus4.d_wdata = 0; bus4.mem_rdata = 0;
        mem[32'h40] = 32'hDEAD_BEEF;
        goto_pos(3);
        reset = 1'b0;
        goto_neg(cyc);
        chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
        chk("rst_d_ack", {31'b0, bus.d_ack}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);

        // Load: mem_en one cycle after request, ack two later.
        goto_pos(cyc + 1); t0 = cyc;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        goto_neg(t0 + 1);
        chk("t1_mem_en", {31'b0, bus.mem_en}, 32'd1);
        chk("t1_mem_addr", bus.mem_addr, 32'h40);
        goto_neg(t0 + 3);
        chk("t1_d_ack", {31'b0, bus.d_ack}, 32'd1);
        chk("t1_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        goto_pos(t0 + 4); bus.d_req = 0;

        // Store: one write strobe, d_rdata keeps the previous load.
        goto_pos(cyc + 1); t0 = cyc;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
        goto_neg(t0 + 1);
        chk("t2_en_we", {31'b0, bus.mem_en && bus.mem_we}, 32'd1);
        chk("t2_mem_addr", bus.mem_addr, 32'h80);
        chk("t2_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        goto_neg(t0 + 2);
        chk("t2_en_off", {31'b0, bus.mem_en}, 32'd0);
        goto_neg(t0 + 3);
        chk("t2_d_ack", {31'b0, bus.d_ack}, 32'd1);
        chk("t2_d_rdata_hold", bus.d_rdata, 32'hDEAD_BEEF);
        goto_pos(t0 + 4); bus.d_req = 0; bus.d_we = 0;
        do_req(1'b1, 1'b0, 32'h80, 32'h0);
        chk("t2_readback", bus.d_rdata, 32'h1234_5678);
        do_req(1'b0, 1'b0, 32'h44, 32'h0);
        chk("fetch_rdata", bus.if_rdata, 32'h5A5A_0044);

        // Both held: starvation guard forces every fourth grant to fetch.
        do_req(1'b1, 1'b0, 32'h48, 32'h0);
        base = g_log.size();
        goto_pos(cyc + 1);
        bus.if_req = 1; bus.if_addr = 32'h200; bus.d_req = 1; bus.d_addr = 32'h300;
        for (int k = 0; k < 80 && seq.size() < 8; k++) begin
            @(negedge clk);
            if (bus.if_ack === 1'b1) seq.push_back(1'b0);
            else if (bus.d_ack === 1'b1) seq.push_back(1'b1);
        end
        @(posedge clk); #1;
        bus.if_req = 0; bus.d_req = 0;
        chk("t3_ack_count", 32'(seq.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t3_dut_order", {31'b0, (k < seq.size()) ? seq[k] : 1'bx}, {31'b0, exp_seq[k]});
            chk("t3_model_order", {31'b0, (base + k < g_log.size()) ? g_log[base + k] : 1'bx},
                {31'b0, exp_seq[k]});
        end

        // MEM_LAT=4 instance: fetch acked exactly 6 cycles after request.
        goto_pos(cyc + 1); t0 = cyc;
        bus4.if_req = 1; bus4.if_addr = 32'h100;
        n_en = 0; ack_c = -1; due = -1;
        for (int k = 0; k < 20 && ack_c < 0; k++) begin
            @(negedge clk);
            if (bus4.mem_en === 1'b1) begin
                n_en++; due = cyc + 4;
                chk("t4_mem_addr", bus4.mem_addr, 32'h100);
            end
            if (bus4.if_ack === 1'b1) ack_c = cyc;
            bus4.mem_rdata = (cyc == due) ? 32'hCAFE_0100 : 32'hBAD0_0000 | 32'(k);
        end
        @(posedge clk); #1;
        bus4.if_req = 0;
        chk("t4_latency", 32'(ack_c - t0), 32'd6);
        chk("t4_en_pulses", 32'(n_en), 32'd1);
        chk("t4_if_rdata", bus4.if_rdata, 32'hCAFE_0100);
        chk("t4_if_stall", {16'b0, if_stall4}, StallEn ? 32'd6 : 32'd0);
        chk("t4_d_stall", {16'b0, d_stall4}, 32'd0);

        // Reset during BUSY aborts with no ack; held request then completes.
        goto_pos(cyc + 1); t0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h140;
        goto_pos(t0 + 1); reset = 1;
        goto_pos(t0 + 2); reset = 0;
        goto_neg(t0 + 2);
        chk("t5_mem_en", {31'b0, bus.mem_en}, 32'd0);
        chk("t5_if_ack", {31'b0, bus.if_ack}, 32'd0);
        chk("t5_if_rdata", bus.if_rdata, 32'd0);
        chk("t5_d_rdata", bus.d_rdata, 32'd0);
        chk("t5_mem_addr", bus.mem_addr, 32'd0);
        chk("t5_mem_wdata", bus.mem_wdata, 32'd0);
        goto_neg(t0 + 4);
        chk("t5_no_early_ack", {31'b0, bus.if_ack}, 32'd0);
        goto_neg(t0 + 5);
        chk("t5_reissue_ack", {31'b0, bus.if_ack}, 32'd1);
        chk("t5_reissue_rdata", bus.if_rdata, 32'h5A5A_0140);
        goto_pos(t0 + 6); bus.if_req = 0;

        // Stall counters: data waits behind a fetch, then takes its own access.
        goto_pos(cyc + 1); reset = 1;
        goto_pos(cyc + 1); reset = 0;
        goto_pos(cyc + 1); t0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h180;
        goto_pos(t0 + 1);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1C0;
        goto_pos(t0 + 4); bus.if_req = 0;
        goto_neg(t0 + 7);
        chk("t6_d_ack", {31'b0, bus.d_ack}, 32'd1);
        goto_pos(t0 + 8); bus.d_req = 0;
        goto_neg(t0 + 9);
        chk("t6_if_stall", {16'b0, if_stall_cnt}, StallEn ? 32'd3 : 32'd0);
        chk("t6_d_stall", {16'b0, d_stall_cnt}, StallEn ? 32'd6 : 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
